// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg
// Shared widths, sample type and slot-to-bit mapping for the I2S output stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int SLOTS_PER_CH = 32;
  localparam int TONE_W       = 32;
  localparam int FRAME_SLOTS  = 2 * SLOTS_PER_CH;
  localparam int SLOT_W       = $clog2(FRAME_SLOTS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Clamp limits expressed at the tone width for signed comparison
  localparam logic signed [TONE_W-1:0] TONE_SAT_HI = 32'sd32767;
  localparam logic signed [TONE_W-1:0] TONE_SAT_LO = -32'sd32768;

  // Slot 0 is the I2S one-BCLK delay; slots 1..16 carry MSB..LSB.
  function automatic logic slot_bit(input sample_t smp, input logic [4:0] slot);
    logic [3:0] idx;
    idx = 4'(5'd16 - slot);
    if (slot >= 5'd1 && slot <= 5'd16)
      return smp[idx];
    return 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_to_sample.sv
// ============================================================================
// tone_to_sample
// Shifts the summed tone down and narrows it to a 16-bit sample.
// Saturating clamp when AUDIO_OUT_SATURATE_EN is defined, else wraparound.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_to_sample
  import audio_pkg::*;
#(
  parameter int TONE_SHIFT = 15
) (
  input  logic [TONE_W-1:0]   TONE_I,
  output logic [SAMPLE_W-1:0] SAMPLE_O,
  output logic                CLIP_O
);

  logic signed [TONE_W-1:0] w_shifted;

  assign w_shifted = $signed(TONE_I) >>> TONE_SHIFT;

`ifdef AUDIO_OUT_SATURATE_EN
  always_comb begin
    SAMPLE_O = w_shifted[SAMPLE_W-1:0];
    CLIP_O   = 1'b0;
    if (w_shifted > TONE_SAT_HI) begin
      SAMPLE_O = SAMPLE_W'(TONE_SAT_HI);
      CLIP_O   = 1'b1;
    end else if (w_shifted < TONE_SAT_LO) begin
      SAMPLE_O = SAMPLE_W'(TONE_SAT_LO);
      CLIP_O   = 1'b1;
    end
  end
`else
  logic w_unused_hi;

  // Upper bits are discarded by design: plain two's-complement wrap
  assign w_unused_hi = ^w_shifted[TONE_W-1:SAMPLE_W];
  assign SAMPLE_O    = w_shifted[SAMPLE_W-1:0];
  assign CLIP_O      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/audio_i2s_out.sv
// ============================================================================
// audio_i2s_out
// Stages the converted tone and serializes it as mono I2S with self-generated
// BCLK/LRCK. Optional saturation: AUDIO_OUT_SATURATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module audio_i2s_out
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int TONE_SHIFT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [TONE_W-1:0] TONE,
  input  logic              TONE_VALID,
  output logic              SAMPLE_REQ,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              OVERRUN,
  output logic              UNDERRUN,
  output logic              CLIP
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic               r_bclk;
  logic [SLOT_W-1:0]  r_bit_cnt;
  logic               r_lrck;
  logic               r_dat;
  logic               r_req;
  sample_t            r_out_smp;
  sample_t            r_stage;
  logic               r_stage_full;
  logic               r_first;
  logic               r_ovr;
  logic               r_udr;

  logic               w_div_wrap;
  logic               w_shift;
  logic [SLOT_W-1:0]  w_bit_next;
  logic               w_frame;
  logic [SAMPLE_W-1:0] w_conv;
  logic               w_conv_clip;

  tone_to_sample #(
    .TONE_SHIFT (TONE_SHIFT)
  ) u_conv (
    .TONE_I   (TONE),
    .SAMPLE_O (w_conv),
    .CLIP_O   (w_conv_clip)
  );

  assign w_div_wrap = (r_div_cnt == c_div_last);
  assign w_shift    = w_div_wrap & r_bclk;
  assign w_bit_next = r_bit_cnt + SLOT_W'(1);
  assign w_frame    = w_shift && (w_bit_next == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div_cnt    <= '0;
      r_bclk       <= 1'b0;
      r_bit_cnt    <= '1;
      r_lrck       <= 1'b0;
      r_dat        <= 1'b0;
      r_req        <= 1'b0;
      r_out_smp    <= '0;
      r_stage      <= '0;
      r_stage_full <= 1'b0;
      r_first      <= 1'b1;
      r_ovr        <= 1'b0;
      r_udr        <= 1'b0;
    end else begin
      r_req <= w_frame;

      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + c_div_w'(1);
      end

      // r_out_smp is already the new word by slot 1, two BCLK halves after the drain
      if (w_shift) begin
        r_bit_cnt <= w_bit_next;
        r_lrck    <= w_bit_next[SLOT_W-1];
        r_dat     <= slot_bit(r_out_smp, w_bit_next[4:0]);
      end

      if (w_frame) begin
        r_first <= 1'b0;
        if (r_stage_full)
          r_out_smp <= r_stage;
        else if (!r_first)
          r_udr <= 1'b1;
      end

      // A strobe coinciding with the drain refills the slot just emptied
      if (TONE_VALID) begin
        r_stage      <= sample_t'(w_conv);
        r_stage_full <= 1'b1;
        if (r_stage_full && !w_frame)
          r_ovr <= 1'b1;
      end else if (w_frame) begin
        r_stage_full <= 1'b0;
      end
    end
  end

`ifdef AUDIO_OUT_SATURATE_EN
  logic r_clip;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_clip <= 1'b0;
    else if (TONE_VALID && w_conv_clip)
      r_clip <= 1'b1;
  end

  assign CLIP = r_clip;
`else
  logic w_unused_clip;

  assign w_unused_clip = w_conv_clip;
  assign CLIP          = 1'b0;
`endif

  assign SAMPLE_REQ  = r_req;
  assign AUD_BCLK    = r_bclk;
  assign AUD_DACLRCK = r_lrck;
  assign AUD_DACDAT  = r_dat;
  assign OVERRUN     = r_ovr;
  assign UNDERRUN    = r_udr;

endmodule

`default_nettype wire

// File: tb/tb_audio_i2s_out.sv
// ============================================================================
// tb_audio_i2s_out
// Randomized stimulus, frame-level reference model and scoreboard for
// audio_i2s_out. Tracks AUDIO_OUT_SATURATE_EN for the conversion model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_i2s_out;

  localparam int D     = 8;
  localparam int SH    = 15;
  localparam int FRAME = 128 * D;
  localparam int FIRST = 2 * D;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] TONE = '0;
  logic        TONE_VALID = 1'b0;
  logic        SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
  logic        OVERRUN, UNDERRUN, CLIP;

  always #5 CLK = ~CLK;

  audio_i2s_out #(
    .CLK_DIV    (D),
    .TONE_SHIFT (SH)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .TONE        (TONE),
    .TONE_VALID  (TONE_VALID),
    .SAMPLE_REQ  (SAMPLE_REQ),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .OVERRUN     (OVERRUN),
    .UNDERRUN    (UNDERRUN),
    .CLIP        (CLIP)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Arithmetic shift then clamp or wrap, straight from the conversion rule
  function automatic logic [15:0] conv(input logic [31:0] x, output logic clip);
    longint t;
    t = longint'($signed(x));
    t = t >>> SH;
    clip = 1'b0;
`ifdef AUDIO_OUT_SATURATE_EN
    if (t > 32767) begin
      clip = 1'b1;
      return 16'h7FFF;
    end
    if (t < -32768) begin
      clip = 1'b1;
      return 16'h8000;
    end
`endif
    return t[15:0];
  endfunction

  // ---------------- reference model (per clock edge) ----------------
  int          ecnt = 0;
  logic        m_rst_edge = 1'b1;
  logic        m_full, m_first, m_ovr, m_udr, m_clip, m_req, m_bclk;
  logic [15:0] m_stage, m_out;
  logic [15:0] exp_q[$];

  always @(posedge CLK) begin
    logic c;
    if (RESET) begin
      ecnt = 0; m_rst_edge = 1'b1;
      m_full = 1'b0; m_first = 1'b1;
      m_ovr = 1'b0; m_udr = 1'b0; m_clip = 1'b0;
      m_req = 1'b0; m_bclk = 1'b0;
      m_stage = '0; m_out = '0;
      exp_q.delete();
    end else begin
      m_rst_edge = 1'b0;
      ecnt++;
      m_bclk = ((ecnt / D) % 2) == 1;
      m_req  = (ecnt >= FIRST) && ((ecnt - FIRST) % FRAME == 0);
      if (m_req) begin
        if (m_full) begin
          m_out  = m_stage;
          m_full = 1'b0;
        end else if (!m_first) begin
          m_udr = 1'b1;
        end
        m_first = 1'b0;
        exp_q.push_back(m_out);
      end
      if (TONE_VALID) begin
        if (m_full) m_ovr = 1'b1;
        m_stage = conv(TONE, c);
        if (c) m_clip = 1'b1;
        m_full = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          fall_cnt = 0;
  logic        prev_bclk = 1'b0;
  logic [63:0] got_d, got_l;

  always @(posedge CLK) begin
    int slot;
    logic [15:0] w;
    logic [63:0] ed, el;
    #1;
    if (m_rst_edge) begin
      check("reset_outputs",
            {57'd0, SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, OVERRUN, UNDERRUN, CLIP}, 64'd0);
      fall_cnt  = 0;
      prev_bclk = 1'b0;
    end else begin
      check("sample_req", {63'd0, SAMPLE_REQ}, {63'd0, m_req});
      check("bclk", {63'd0, AUD_BCLK}, {63'd0, m_bclk});
      check("flags", {61'd0, OVERRUN, UNDERRUN, CLIP}, {61'd0, m_ovr, m_udr, m_clip});
      if (prev_bclk && !AUD_BCLK) begin
        slot = fall_cnt % 64;
        got_d[slot] = AUD_DACDAT;
        got_l[slot] = AUD_DACLRCK;
        fall_cnt++;
        if (slot == 63) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_queue: got empty expected one word at t=%0t", $time);
          end else begin
            w  = exp_q.pop_front();
            ed = '0;
            for (int s = 1; s <= 16; s++) begin
              ed[s]      = w[16-s];
              ed[32 + s] = w[16-s];
            end
            el = {32'hFFFF_FFFF, 32'h0};
            check("frame_data", got_d, ed);
            check("frame_lrck", got_l, el);
          end
        end
      end
      prev_bclk = AUD_BCLK;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ecnt(input int n);
    int guard;
    guard = 0;
    while (ecnt != n) begin
      @(negedge CLK);
      guard++;
      if (guard > 40000) begin
        $display("FAIL wait_ecnt: got ecnt %0d expected %0d", ecnt, n);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "stimulus timing lost");
      end
    end
  endtask

  task automatic strobe(input int edge_n, input logic [31:0] v);
    wait_ecnt(edge_n - 1);
    TONE       = v;
    TONE_VALID = 1'b1;
    @(negedge CLK);
    TONE_VALID = 1'b0;
  endtask

  function automatic logic [31:0] rnd_tone();
    logic signed [31:0] v;
    v = $signed($urandom);
    return v >>> $urandom_range(0, 16);
  endfunction

  logic [31:0] dir_vals [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_8000,
                                32'h0040_0000, 32'hFFC0_0001};
  int modes [6] = '{0, 1, 2, 0, 3, 0};

  initial begin
    int F, a, mode, vi;
    logic [31:0] v;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // frame 0 carries the reset sample; frame 1 carries 0x0024
    F = FIRST;
    strobe(F + 100, 32'h0012_3480);
    F += FRAME;
    vi = 0;
    for (int f = 0; f < 12; f++) begin
      mode = (f < 6) ? modes[f] : int'($urandom_range(0, 3));
      v = (vi < 5) ? dir_vals[vi] : rnd_tone();
      vi++;
      case (mode)
        0: strobe(F + int'($urandom_range(1, 1000)), v);
        1: begin
          a = int'($urandom_range(1, 500));
          strobe(F + a, rnd_tone());
          strobe(F + a + int'($urandom_range(2, 500)), v);
        end
        2: ;
        default: begin
          strobe(F + int'($urandom_range(1, 1000)), rnd_tone());
          strobe(F + FRAME, v);
        end
      endcase
      F += FRAME;
    end

    // abandon a frame mid-word at bit_cnt = 20
    wait_ecnt(F + 20 * 2 * D);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    F = FIRST;
    strobe(F + 50, rnd_tone());
    strobe(F + FRAME + 50, 32'h0012_3480);
    wait_ecnt(FIRST + 3 * FRAME + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/audio_i2s_out.md
# audio_i2s_out

Output stage downstream of the per-key synthesis data path. Captures the 32-bit summed `TONE` word once the key sweep for a sample period is complete, and scales it to a 16-bit signed sample. Serializes that sample as I2S (mono, duplicated to both channels) to the audio DAC, generating BCLK and LRCK itself. Pulses a frame-rate request back to the synthesis FSM so the next sweep is paced by the DAC frame.

## Interface
- `CLK_DIV`, 8, CLK cycles per BCLK half-period; must be ≥2. At 50 MHz: BCLK 3.125 MHz, frame rate 48.828 kHz.
- `TONE_SHIFT`, 15, arithmetic right shift applied to `TONE` before 16-bit conversion.
- `CLK`  in  1  system clock; all logic on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `TONE`  in  32  signed summed tone from the data path.
- `TONE_VALID`  in  1  one-cycle strobe: `TONE` is final for this sample period.
- `SAMPLE_REQ`  out  1  one-cycle pulse at every frame start; FSM begins the next key sweep.
- `AUD_BCLK`  out  1  bit clock.
- `AUD_DACLRCK`  out  1  0 = left, 1 = right.
- `AUD_DACDAT`  out  1  serial data, MSB first, changes on BCLK falling edge.
- `OVERRUN`  out  1  sticky: a staged sample was overwritten before use.
- `UNDERRUN`  out  1  sticky: a frame started with no new staged sample.
- `CLIP`  out  1  sticky: conversion saturated. Constant 0 without the macro.

## Operation
- **Divider**
  - `div_cnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and `AUD_BCLK` toggles.
  - A 1→0 toggle is a *shift event*.
- **Bit counter**
  - `bit_cnt` (6 bits, 64 slots/frame) increments on each shift event and wraps 63→0.
  - `AUD_DACLRCK` = `bit_cnt[5]`.
  - Slot `s = bit_cnt[4:0]`: `AUD_DACDAT` = `out_smp[16-s]` for s in 1..16, else 0. This gives the I2S one-BCLK delay after the LRCK edge.
- **Frame start** (shift event where `bit_cnt` wraps to 0):
  - `SAMPLE_REQ` pulses.
  - If staging is full: `out_smp` ← staged value and staging empties.
  - Otherwise: `out_smp` holds its previous value and `UNDERRUN` is set. The first frame after reset is exempt.
- **Staging** (one entry)
  - On `TONE_VALID`, staged ← convert(`TONE`) and staging is marked full.
  - If staging was already full and is not drained in the same cycle: the value is overwritten and `OVERRUN` is set.
- **Conversion**
  - `t = TONE >>> TONE_SHIFT` (sign-preserving).
  - With saturation: clamp `t` to [-32768, 32767].
  - Without saturation: take `t[15:0]`.
- **Simultaneous `TONE_VALID` and frame-start drain:** the drain takes the old staged value, and the new value becomes staged.
  - Staging was full: no OVERRUN.
  - Staging was empty: UNDERRUN is set (outside the exemption) and the new value is staged.
- **Flags:** `OVERRUN`/`UNDERRUN`/`CLIP` clear only on `RESET`.

## Timing
- **Reset values:** `AUD_BCLK`=0, `AUD_DACLRCK`=0, `AUD_DACDAT`=0, `SAMPLE_REQ`=0, all flags 0, `out_smp`=0, staging empty, `div_cnt`=0, `bit_cnt`=63.
- **First frame start:** registered in cycle 2·CLK_DIV after `RESET` deasserts, so `SAMPLE_REQ` is high in cycle 2·CLK_DIV+1.
  - The first BCLK rise follows CLK_DIV cycles after reset deasserts, the first fall 2·CLK_DIV.
- **Frame period:** 128·CLK_DIV cycles. `SAMPLE_REQ` has exactly that spacing.
- **Output alignment:** `AUD_DACLRCK` and `AUD_DACDAT` are registered and update in the same cycle as the `AUD_BCLK` fall.
- **Conversion latency:** one cycle from `TONE_VALID` to staged value.
- **Staged sample reaches the DAC:**
  - It is transmitted only if staged by the cycle of the next frame-start drain.
  - MSB appears on the second shift event of that frame (LRCK low, slot 1).
- **Reset mid-frame:** all state is reinitialized as above; a partial word is abandoned, with no glitch beyond `AUD_BCLK` forced to 0.

## Configuration
- `AUDIO_OUT_SATURATE_EN`
  - Defined: clamp conversion; `CLIP` is set whenever clamping occurs on a captured `TONE`.
  - Undefined: wraparound truncation; `CLIP` is tied 0 and no clamp logic is built.

## Structure
- **`audio_pkg`:**
  - `SAMPLE_W` = 16
  - `SLOTS_PER_CH` = 32
  - `typedef logic signed [15:0] sample_t`
  - conversion function signature constants
- **Sub-module `tone_to_sample`:** combinational shift + clamp/truncate, with `CLIP_O` output; contains the macro-controlled logic.
- **Top `audio_i2s_out`:** divider, bit counter, staging register, shift output, flags.

## Test plan
- **Reset, CLK_DIV=8:** release reset → `SAMPLE_REQ` at cycle 17. BCLK period is 16 cycles, LRCK period is 1024 cycles. No UNDERRUN after the first frame.
- **Serialization:** `TONE`=0x0012_3480, TONE_SHIFT=15, strobe before frame start → sample 0x0024. Both channels, slots 1..16, shift out 0000 0000 0010 0100; slots 0 and 17..31 are 0.
- **Saturation:** `TONE`=0x7FFF_FFFF → 0x7FFF with `CLIP`=1 (macro on). Without the macro → 0xFFFF with `CLIP`=0. `TONE`=0x8000_0000 → 0x8000 with the macro.
- **Overrun:** two `TONE_VALID` strobes (values A, B) within one frame → `OVERRUN`=1 and B transmitted. A strobe in the exact drain cycle while staging is full → no OVERRUN, and the new value appears in the following frame.
- **Underrun:** no `TONE_VALID` for a full frame → `UNDERRUN`=1 and the previous sample is repeated bit-exactly.
- **Mid-frame reset:** assert `RESET` at bit_cnt=20 → next cycle all outputs at reset values; the timing of the first post-reset frame start matches scenario 1.
